// File: rtl/tlb_req_arb_if.sv
// tlb_req_arb_if: bundle of the I-side, D-side and TLB lookup-port signals
// around the TLB request arbiter.
//   master : the arbiter (drives acks, responses and the TLB lookup pulse)
//   slave  : the clients/TLB environment around it
interface tlb_req_arb_if #(
    parameter int VA_W  = 52,
    parameter int RSP_W = 57
);
    // I-side requester
    logic             iside_req;
    logic [VA_W-1:0]  iside_va;
    logic             iside_ack;
    logic             iside_rsp_valid;
    logic [RSP_W-1:0] iside_rsp;
    // D-side requester
    logic             dside_req;
    logic [VA_W-1:0]  dside_va;
    logic             dside_ack;
    logic             dside_rsp_valid;
    logic [RSP_W-1:0] dside_rsp;
    // TLB lookup port
    logic             tlb_req;
    logic             tlb_sel;
    logic [VA_W-1:0]  tlb_va;
    logic             tlb_rsp_valid;
    logic [RSP_W-1:0] tlb_rsp;
    // status
    logic             busy;
    logic             spurious_err;

    modport master (
        input  iside_req, iside_va, dside_req, dside_va, tlb_rsp_valid, tlb_rsp,
        output iside_ack, iside_rsp_valid, iside_rsp,
        output dside_ack, dside_rsp_valid, dside_rsp,
        output tlb_req, tlb_sel, tlb_va, busy, spurious_err
    );

    modport slave (
        output iside_req, iside_va, dside_req, dside_va, tlb_rsp_valid, tlb_rsp,
        input  iside_ack, iside_rsp_valid, iside_rsp,
        input  dside_ack, dside_rsp_valid, dside_rsp,
        input  tlb_req, tlb_sel, tlb_va, busy, spurious_err
    );
endinterface

// File: rtl/tlb_req_arb.sv
// tlb_req_arb: shares the single TLB lookup port between the I-side and
// D-side miss logic. One lookup outstanding at a time; the TLB response is
// steered back to the side that owns it and held there.
//
// Optional feature macro: TLB_REQ_ARB_RR_EN
//   defined   -> round-robin tie-break via a last_grant register
//   undefined -> fixed priority, I-side wins every tie
//
// Side index convention throughout: 0 = I-side, 1 = D-side.
module tlb_req_arb #(
    parameter int VA_W  = 52,
    parameter int RSP_W = 57
) (
    input  logic          clk,
    input  logic          reset,
    tlb_req_arb_if.master bus
);
    localparam int SIDES = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic                          tlb_req_q, tlb_req_d;
    logic                          tlb_sel_q, tlb_sel_d;
    logic [VA_W-1:0]               tlb_va_q, tlb_va_d;
    logic [SIDES-1:0]              ack_q, ack_d;
    logic [SIDES-1:0]              rv_q, rv_d;
    logic [SIDES-1:0][RSP_W-1:0]   rsp_q, rsp_d;
    logic                          spur_q, spur_d;

    logic [SIDES-1:0]              req;
    logic [SIDES-1:0][VA_W-1:0]    va;
    logic                          win;

    assign req   = {bus.dside_req, bus.iside_req};
    assign va[0] = bus.iside_va;
    assign va[1] = bus.dside_va;

`ifdef TLB_REQ_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // On a tie the side not granted last time wins; otherwise the lone requester.
    always_comb begin
        win = req[1];
        if (&req) win = ~last_grant_q;
    end
`else
    // Fixed priority: I-side whenever it asks, D-side only when alone.
    always_comb begin
        win = ~req[0];
    end
`endif

    // Next-state and registered-output logic for the IDLE/WAIT machine.
    always_comb begin
        state_d   = state_q;
        tlb_req_d = 1'b0;
        tlb_sel_d = tlb_sel_q;
        tlb_va_d  = tlb_va_q;
        ack_d     = '0;
        rv_d      = '0;
        rsp_d     = rsp_q;
        spur_d    = spur_q;
`ifdef TLB_REQ_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A response with nothing outstanding is dropped but remembered.
                if (bus.tlb_rsp_valid) spur_d = 1'b1;
                if (|req) begin
                    state_d    = S_WAIT;
                    tlb_req_d  = 1'b1;
                    tlb_sel_d  = win;
                    tlb_va_d   = va[win];
                    ack_d[win] = 1'b1;
`ifdef TLB_REQ_ARB_RR_EN
                    last_grant_d = win;
`endif
                end
            end
            S_WAIT: begin
                // Requests are deliberately ignored here; they stay pending on
                // the held req level until the machine is back in IDLE.
                if (bus.tlb_rsp_valid) begin
                    rsp_d[tlb_sel_q] = bus.tlb_rsp;
                    rv_d[tlb_sel_q]  = 1'b1;
                    state_d          = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; synchronous reset abandons any lookup.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tlb_req_q <= 1'b0;
            tlb_sel_q <= 1'b0;
            tlb_va_q  <= '0;
            ack_q     <= '0;
            rv_q      <= '0;
            rsp_q     <= '0;
            spur_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tlb_req_q <= tlb_req_d;
            tlb_sel_q <= tlb_sel_d;
            tlb_va_q  <= tlb_va_d;
            ack_q     <= ack_d;
            rv_q      <= rv_d;
            rsp_q     <= rsp_d;
            spur_q    <= spur_d;
        end
    end

`ifdef TLB_REQ_ARB_RR_EN
    // Reset to D-side so the I-side wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end
`endif

    assign bus.tlb_req         = tlb_req_q;
    assign bus.tlb_sel         = tlb_sel_q;
    assign bus.tlb_va          = tlb_va_q;
    assign bus.iside_ack       = ack_q[0];
    assign bus.dside_ack       = ack_q[1];
    assign bus.iside_rsp_valid = rv_q[0];
    assign bus.dside_rsp_valid = rv_q[1];
    assign bus.iside_rsp       = rsp_q[0];
    assign bus.dside_rsp       = rsp_q[1];
    assign bus.busy            = (state_q == S_WAIT);
    assign bus.spurious_err    = spur_q;

endmodule

// File: tb/tb_tlb_req_arb.sv
// tb_tlb_req_arb: scoreboard bench for tlb_req_arb. Expected lookups are
// queued when requests are driven; expected responses are queued when a
// lookup is observed; both are popped and compared as the DUT emits them.
module tb_tlb_req_arb;
    localparam int VA_W  = 52;
    localparam int RSP_W = 57;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tlb_req_arb_if #(.VA_W(VA_W), .RSP_W(RSP_W)) bus ();

    tlb_req_arb #(.VA_W(VA_W), .RSP_W(RSP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic            sel;
        logic [VA_W-1:0] va;
        int              at;
    } lk_t;

    typedef struct {
        logic             sel;
        logic [RSP_W-1:0] rsp;
        int               at;
    } rs_t;

    lk_t lk_q[$];
    rs_t rs_q[$];

    int               n_chk = 0;
    int               n_pass = 0;
    int               cyc = 0;
    int               lat = 2;
    int               due = 0;
    bit               due_v = 1'b0;
    logic [RSP_W-1:0] due_rsp;
    bit               m_busy = 1'b0;
    bit               exp_spur = 1'b0;
    logic [RSP_W-1:0] exp_rsp [2];

    // TLB model payload: for va 0x12345 this yields 0xABCDE00005
    function automatic logic [RSP_W-1:0] rsp_of(logic [VA_W-1:0] v);
        return {5'b0, v} ^ 57'hAB_CDE1_2340;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic drive_rsp(logic [RSP_W-1:0] d);
        bus.tlb_rsp_valid = 1'b1;
        bus.tlb_rsp       = d;
        if (m_busy) m_busy = 1'b0;
        else        exp_spur = 1'b1;
    endtask

    task automatic monitor();
        lk_t e;
        rs_t r;
        if (bus.tlb_req) begin
            chk("lk_pending", 64'(lk_q.size() != 0), 64'd1);
            if (lk_q.size() != 0) begin
                e = lk_q.pop_front();
                chk("tlb_sel", 64'(bus.tlb_sel), 64'(e.sel));
                chk("tlb_va", 64'(bus.tlb_va), 64'(e.va));
                if (e.at != 0) chk("lk_cycle", 64'(cyc), 64'(e.at));
                chk("ack_win", 64'(e.sel ? bus.dside_ack : bus.iside_ack), 64'd1);
                chk("ack_lose", 64'(e.sel ? bus.iside_ack : bus.dside_ack), 64'd0);
                m_busy  = 1'b1;
                due_v   = 1'b1;
                due     = cyc + lat;
                due_rsp = rsp_of(e.va);
                rs_q.push_back('{e.sel, rsp_of(e.va), cyc + lat + 1});
            end
        end else begin
            chk("ack_idle", 64'({bus.dside_ack, bus.iside_ack}), 64'd0);
        end
        if (bus.iside_rsp_valid || bus.dside_rsp_valid) begin
            chk("rv_pending", 64'(rs_q.size() != 0), 64'd1);
            if (rs_q.size() != 0) begin
                r = rs_q.pop_front();
                chk("rv_side", 64'({bus.dside_rsp_valid, bus.iside_rsp_valid}),
                    r.sel ? 64'd2 : 64'd1);
                chk("rv_cycle", 64'(cyc), 64'(r.at));
                exp_rsp[r.sel] = r.rsp;
            end
        end
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("iside_rsp", 64'(bus.iside_rsp), 64'(exp_rsp[0]));
        chk("dside_rsp", 64'(bus.dside_rsp), 64'(exp_rsp[1]));
        chk("spurious_err", 64'(bus.spurious_err), 64'(exp_spur));
    endtask

    // One cycle: sample at the falling edge, then drive the TLB model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        if (due_v && cyc == due) begin
            drive_rsp(due_rsp);
            due_v = 1'b0;
        end else begin
            bus.tlb_rsp_valid = 1'b0;
            bus.tlb_rsp       = RSP_W'({$urandom(), $urandom()});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_busy = 1'b0;
        rs_q.delete();
        exp_rsp[0] = '0;
        exp_rsp[1] = '0;
        exp_spur = 1'b0;
        tick();
        chk("rst_tlb_req", 64'(bus.tlb_req), 64'd0);
        chk("rst_tlb_sel", 64'(bus.tlb_sel), 64'd0);
        chk("rst_tlb_va", 64'(bus.tlb_va), 64'd0);
        chk("rst_rv", 64'({bus.dside_rsp_valid, bus.iside_rsp_valid}), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int ngr;
        logic [VA_W-1:0] v;
        reset = 1'b1;
        bus.iside_req = 1'b0;
        bus.iside_va  = '0;
        bus.dside_req = 1'b0;
        bus.dside_va  = '0;
        bus.tlb_rsp_valid = 1'b0;
        bus.tlb_rsp = '0;
        exp_rsp[0] = '0;
        exp_rsp[1] = '0;
        tick();
        do_reset();

        // single I-side lookup with the documented payload
        bus.iside_req = 1'b1;
        bus.iside_va  = 52'h12345;
        lk_q.push_back('{1'b0, 52'h12345, cyc + 1});
        tick();
        bus.iside_req = 1'b0;
        repeat (4) tick();
        chk("t1_iside_rsp", 64'(bus.iside_rsp), 64'h00AB_CDE0_0005);
        chk("t1_dside_rsp", 64'(bus.dside_rsp), 64'd0);

        // tie: both requests held high, TLB latency 2
        do_reset();
        n = cyc;
        bus.iside_req = 1'b1;
        bus.iside_va  = 52'h111;
        bus.dside_req = 1'b1;
        bus.dside_va  = 52'h222;
`ifdef TLB_REQ_ARB_RR_EN
        ngr = 4;
        for (int k = 0; k < ngr; k++)
            lk_q.push_back('{k[0], k[0] ? 52'h222 : 52'h111, n + 1 + 4 * k});
`else
        ngr = 3;
        for (int k = 0; k < ngr; k++)
            lk_q.push_back('{1'b0, 52'h111, n + 1 + 4 * k});
`endif
        repeat (4 * (ngr - 1) + 1) tick();
        bus.iside_req = 1'b0;
        bus.dside_req = 1'b0;
        repeat (4) tick();
        chk("tie_all_granted", 64'(lk_q.size()), 64'd0);

        // late D-side request raised while busy
        n = cyc;
        bus.iside_req = 1'b1;
        bus.iside_va  = 52'h5A5A5;
        lk_q.push_back('{1'b0, 52'h5A5A5, n + 1});
        lk_q.push_back('{1'b1, 52'h3C3C3, n + 5});
        tick();
        bus.iside_req = 1'b0;
        bus.dside_req = 1'b1;
        bus.dside_va  = 52'h3C3C3;
        repeat (4) tick();
        bus.dside_req = 1'b0;
        repeat (4) tick();

        // single requests across TLB latencies, including same-cycle response
        for (int k = 0; k < 4; k++) begin
            lat = k;
            v = VA_W'({$urandom(), $urandom()});
            if (k[0]) begin
                bus.dside_req = 1'b1;
                bus.dside_va  = v;
            end else begin
                bus.iside_req = 1'b1;
                bus.iside_va  = v;
            end
            lk_q.push_back('{k[0], v, cyc + 1});
            tick();
            bus.iside_req = 1'b0;
            bus.dside_req = 1'b0;
            repeat (lat + 3) tick();
        end
        lat = 2;

        // spurious response in IDLE
        tick();
        drive_rsp(57'h1F_FFFF_FFFF_FFFF);
        repeat (3) tick();
        chk("spur_sticky", 64'(bus.spurious_err), 64'd1);

        // reset in WAIT; the abandoned response lands 2 cycles later
        bus.iside_req = 1'b1;
        bus.iside_va  = 52'hCAFE;
        lk_q.push_back('{1'b0, 52'hCAFE, cyc + 1});
        tick();
        bus.iside_req = 1'b0;
        do_reset();
        chk("rst_spur", 64'(bus.spurious_err), 64'd0);
        chk("rst_irsp", 64'(bus.iside_rsp), 64'd0);
        repeat (3) tick();
        chk("post_rst_spur", 64'(bus.spurious_err), 64'd1);

        chk("drain_lk", 64'(lk_q.size()), 64'd0);
        chk("drain_rs", 64'(rs_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
